// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump path: FSM encoding, default geometry
// of the register bank and a small helper for counter widths.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } dump_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_BYTE_WIDTH = 8;

    localparam int BYTES_PER_WORD = DEFAULT_DATA_WIDTH / DEFAULT_BYTE_WIDTH;
    localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_WIDTH;

    // Width of a counter that indexes n items; never narrower than one bit.
    function automatic int calc_index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Captures one word and presents it as a sequence of bytes, least-significant
// byte first, on a valid/ready interface. o_last marks the cycle on which the
// final byte of the word is accepted. Also intended for the data-memory dump.
module word_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_word,
    output logic [BYTE_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last
);
    import debug_pkg::*;

    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W  = calc_index_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [DATA_WIDTH-1:0] word_reg;
    logic [IDX_W-1:0]      byte_idx_reg;
    logic                  valid_reg;
    logic                  xfer;
    logic [BYTE_WIDTH-1:0] byte_lane [NBYTES];

    // Slice the captured word into byte lanes; lane gi holds bits [gi*BW +: BW].
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign byte_lane[gi] = word_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    // Valid comes straight from a register, so it never follows i_ready.
    assign xfer    = valid_reg & i_ready;
    assign o_last  = xfer & (byte_idx_reg == LAST_IDX);
    assign o_valid = valid_reg;
    assign o_data  = valid_reg ? byte_lane[byte_idx_reg] : '0;

    // Capture on load, advance one lane per accepted byte, drop valid after the last.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            word_reg     <= '0;
            byte_idx_reg <= '0;
            valid_reg    <= 1'b0;
        end else if (i_load) begin
            word_reg     <= i_word;
            byte_idx_reg <= '0;
            valid_reg    <= 1'b1;
        end else if (xfer) begin
            if (byte_idx_reg == LAST_IDX) begin
                byte_idx_reg <= '0;
                valid_reg    <= 1'b0;
            end else begin
                byte_idx_reg <= byte_idx_reg + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/register_dump_unit.sv
// Debug-path reader for the ID-stage register bank. On i_start it walks every
// register through the bank's asynchronous read port and streams each word
// out byte by byte to the UART transmitter. Meant for use with the pipeline halted.
module register_dump_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_reg_addr,
    input  logic [DATA_WIDTH-1:0] i_reg_data,
    output logic [BYTE_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);
    import debug_pkg::*;

    dump_state_t           state_reg, state_next;
    logic [ADDR_WIDTH-1:0] reg_idx_reg, reg_idx_next;
    logic                  done_reg, done_next;
    logic                  ser_load;
    logic                  ser_last;

    word_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_serializer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (ser_load),
        .i_word  (i_reg_data),
        .o_data  (o_tx_data),
        .o_valid (o_tx_valid),
        .i_ready (i_tx_ready),
        .o_last  (ser_last)
    );

    // State, register index and the registered done pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg   <= IDLE;
            reg_idx_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            reg_idx_reg <= reg_idx_next;
            done_reg    <= done_next;
        end
    end

    // Next-state logic: LOAD samples the bank for one cycle, SEND waits for the
    // serializer to finish the word, then moves to the next register or stops.
    always_comb begin
        state_next   = state_reg;
        reg_idx_next = reg_idx_reg;
        done_next    = 1'b0;
        ser_load     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next   = LOAD;
                    reg_idx_next = '0;
                end
            end
            LOAD: begin
                ser_load   = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (ser_last) begin
                    if (&reg_idx_reg) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        reg_idx_next = reg_idx_reg + ADDR_WIDTH'(1);
                        state_next   = LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_reg_addr = reg_idx_reg;
    assign o_busy     = (state_reg != IDLE);
    assign o_done     = done_reg;

endmodule
